// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch (IF)
// and memory access (MEM). It runs one transaction at a time as consecutive
// byte accesses, and it assembles or scatters the data in little-endian order.
// Optional feature macro: MEM_ARB_BRANCH_ABORT_EN. When it is defined, a branch
// flush aborts an in-flight IF read straight away. When it is undefined, the
// read runs to the end and its completion pulse is suppressed.
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        branch_flag_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic [31:0] if_data_out,
    output logic        if_done_out,
    input  logic        mem_req_in,
    input  logic        mem_wr_in,
    input  logic [2:0]  mem_len_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    output logic [31:0] mem_rdata_out,
    output logic        mem_done_out,
    input  logic [7:0]  ram_din_in,
    output logic [7:0]  ram_dout_out,
    output logic [31:0] ram_a_out,
    output logic        ram_wr_out
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                owner_mem;   // 1: MEM owns the transaction, 0: IF
    logic                discard;     // IF read flushed; suppress its done pulse
    logic [CNT_W-1:0]    cnt;         // edges elapsed since the grant
    logic [CNT_W-1:0]    len;         // byte count of the transaction
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   asm_data;

    logic                grant_mem_c;
    logic                grant_if_c;
    logic                flush_c;
    logic                abort_c;
    logic                rd_last_c;
    logic                wr_last_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [CNT_W-1:0]    len_dec_c;
    logic [IDX_W-1:0]    rd_idx_c;
    logic [IDX_W-1:0]    wr_idx_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [BYTE_W-1:0]   wr_byte_c;

    // Byte-count decode: only 1 and 2 are sub-word, everything else is a word
    always_comb begin
        len_dec_c = CNT_W'(4);
        case (mem_len_in)
            3'd1:    len_dec_c = CNT_W'(1);
            3'd2:    len_dec_c = CNT_W'(2);
            default: len_dec_c = CNT_W'(4);
        endcase
    end

    // Byte indexing: reads capture byte cnt-1, writes present byte cnt+1
    assign cnt_inc_c = cnt + CNT_W'(1);
    assign rd_idx_c  = IDX_W'(cnt - CNT_W'(1));
    assign wr_idx_c  = IDX_W'(cnt_inc_c);
    assign rd_last_c = (cnt == len);
    assign wr_last_c = (cnt_inc_c == len);
    assign wr_byte_c = wdata[{wr_idx_c, 3'b000} +: BYTE_W];

    // Assembly word with the byte arriving from RAM merged in
    always_comb begin
        rd_word_c = asm_data;
        rd_word_c[{rd_idx_c, 3'b000} +: BYTE_W] = ram_din_in;
    end

    // Branch flush seen while IF owns a read
    assign flush_c = (state == READ) && !owner_mem && branch_flag_in;

`ifdef MEM_ARB_BRANCH_ABORT_EN
    assign abort_c = flush_c;
`else
    assign abort_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Next-state logic and grant decisions
    always_comb begin
        state_nxt   = state;
        grant_mem_c = 1'b0;
        grant_if_c  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_in) begin
                    grant_mem_c = 1'b1;
                    state_nxt   = mem_wr_in ? WRITE : READ;
                end else if (if_req_in && !branch_flag_in) begin
                    grant_if_c = 1'b1;
                    state_nxt  = READ;
                end
            end
            READ: begin
                if (abort_c) begin
                    state_nxt = IDLE;
                end else if (rd_last_c) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                if (wr_last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: address/data sequencing, byte assembly and completion pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner_mem     <= 1'b0;
            discard       <= 1'b0;
            cnt           <= '0;
            len           <= '0;
            wdata         <= '0;
            asm_data      <= '0;
            if_data_out   <= '0;
            if_done_out   <= 1'b0;
            mem_rdata_out <= '0;
            mem_done_out  <= 1'b0;
            ram_dout_out  <= '0;
            ram_a_out     <= '0;
            ram_wr_out    <= 1'b0;
        end else if (rdy_in) begin
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    asm_data   <= '0;
                    discard    <= 1'b0;
                    ram_wr_out <= 1'b0;
                    if (grant_mem_c) begin
                        owner_mem <= 1'b1;
                        ram_a_out <= mem_addr_in;
                        len       <= len_dec_c;
                        wdata     <= mem_wdata_in;
                        if (mem_wr_in) begin
                            ram_wr_out   <= 1'b1;
                            ram_dout_out <= mem_wdata_in[BYTE_W-1:0];
                        end
                    end else if (grant_if_c) begin
                        owner_mem <= 1'b0;
                        ram_a_out <= if_addr_in;
                        len       <= CNT_W'(4);
                    end
                end
                READ: begin
                    if (abort_c) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c < len) begin
                            ram_a_out <= ram_a_out + ADDR_W'(1);
                        end
                        if (cnt != '0) begin
                            asm_data <= rd_word_c;
                        end
                        if (flush_c) begin
                            discard <= 1'b1;
                        end
                        if (rd_last_c) begin
                            if (owner_mem) begin
                                mem_rdata_out <= rd_word_c;
                                mem_done_out  <= 1'b1;
                            end else if (!(discard || flush_c)) begin
                                if_data_out <= rd_word_c;
                                if_done_out <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    cnt <= cnt_inc_c;
                    if (wr_last_c) begin
                        ram_wr_out   <= 1'b0;
                        mem_done_out <= 1'b1;
                    end else begin
                        ram_a_out    <= ram_a_out + ADDR_W'(1);
                        ram_dout_out <= wr_byte_c;
                        ram_wr_out   <= 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transactions against a byte RAM model,
// with a completion scoreboard and a RAM write-strobe scoreboard.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        branch_flag_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_data_out;
    logic        if_done_out;
    logic        mem_req_in;
    logic        mem_wr_in;
    logic [2:0]  mem_len_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [31:0] mem_rdata_out;
    logic        mem_done_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .branch_flag_in (branch_flag_in),
        .if_req_in      (if_req_in),
        .if_addr_in     (if_addr_in),
        .if_data_out    (if_data_out),
        .if_done_out    (if_done_out),
        .mem_req_in     (mem_req_in),
        .mem_wr_in      (mem_wr_in),
        .mem_len_in     (mem_len_in),
        .mem_addr_in    (mem_addr_in),
        .mem_wdata_in   (mem_wdata_in),
        .mem_rdata_out  (mem_rdata_out),
        .mem_done_out   (mem_done_out),
        .ram_din_in     (ram_din_in),
        .ram_dout_out   (ram_dout_out),
        .ram_a_out      (ram_a_out),
        .ram_wr_out     (ram_wr_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [7:0]  ram [0:65535];
    logic        prev_wr = 1'b0;
    logic [31:0] prev_a = 32'd0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous byte RAM (latency 1), preloaded on the first edge
    always @(posedge clk_in) begin
        if (cyc == 0) begin
            ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05;
            ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
            ram[16'h0200] <= 8'h6F; ram[16'h0201] <= 8'h00;
            ram[16'h0202] <= 8'h80; ram[16'h0203] <= 8'h00;
            ram[16'h0300] <= 8'hEF; ram[16'h0301] <= 8'hBE;
            ram[16'h0302] <= 8'hAD; ram[16'h0303] <= 8'hDE;
            ram[16'h0400] <= 8'hB7; ram[16'h0401] <= 8'h12;
            ram[16'h0402] <= 8'h34; ram[16'h0403] <= 8'h56;
            ram[16'h1000] <= 8'hAB; ram[16'h1001] <= 8'hCD;
        end else if (ram_wr_out) begin
            ram[ram_a_out[15:0]] <= ram_dout_out;
        end
        ram_din_in <= ram[ram_a_out[15:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic expect_done(input bit is_mem, input bit chk_data, input logic [31:0] data, input int at);
        exp_t e;
        e.is_mem = is_mem; e.chk_data = chk_data; e.data = data; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wq.push_back(w);
    endtask

    task automatic wait_done(input bit is_mem);
        int k;
        k = 0;
        forever begin
            @(negedge clk_in);
            k++;
            if ((is_mem ? mem_done_out : if_done_out) == 1'b1) break;
            if (k >= 60) begin
                fail_now(is_mem ? "mem_done_timeout" : "if_done_timeout");
                break;
            end
        end
    endtask

    task automatic if_txn(input logic [31:0] addr);
        if_addr_in = addr;
        if_req_in  = 1'b1;
        wait_done(1'b0);
        if_req_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic mem_txn(input bit wr, input logic [2:0] len, input logic [31:0] addr, input logic [31:0] wd);
        mem_wr_in = wr; mem_len_in = len; mem_addr_in = addr; mem_wdata_in = wd;
        mem_req_in = 1'b1;
        wait_done(1'b1);
        mem_req_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_a"}, ram_a_out, 32'd0);
        chk({tag, "_ram_wr"}, 32'(ram_wr_out), 32'd0);
        chk({tag, "_ram_dout"}, 32'(ram_dout_out), 32'd0);
        chk({tag, "_if_data"}, if_data_out, 32'd0);
        chk({tag, "_if_done"}, 32'(if_done_out), 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata_out, 32'd0);
        chk({tag, "_mem_done"}, 32'(mem_done_out), 32'd0);
    endtask

    // Completion monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk_in) begin
        if (if_done_out || mem_done_out) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                chk("done_owner", 32'(mem_done_out), 32'(exp_q[0].is_mem));
                chk("done_other_low", 32'(if_done_out & mem_done_out), 32'd0);
                chk("done_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                if (exp_q[0].chk_data)
                    chk("done_data", exp_q[0].is_mem ? mem_rdata_out : if_data_out, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Write monitor: each new strobed address must match the expected write list
    always @(negedge clk_in) begin
        if (ram_wr_out && (!prev_wr || ram_a_out != prev_a)) begin
            if (wq.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                chk("wr_addr", ram_a_out, wq[0].a);
                chk("wr_data", 32'(ram_dout_out), 32'(wq[0].d));
                void'(wq.pop_front());
            end
        end
        prev_wr <= ram_wr_out;
        prev_a  <= ram_a_out;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_in = 1'b1; rdy_in = 1'b1; branch_flag_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0;
        mem_req_in = 1'b0; mem_wr_in = 1'b0; mem_len_in = '0;
        mem_addr_in = '0; mem_wdata_in = '0;
        repeat (2) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // IF fetch of 0x100, with its address walk
        c = cyc;
        expect_done(1'b0, 1'b1, 32'h0000_0513, c + 6);
        fork
            if_txn(32'h0000_0100);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk_in);
                    chk("if_addr_step", ram_a_out, 32'h0000_0100 + 32'(i));
                end
            end
        join

        // Simultaneous requests: MEM wins, then IF is served
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h0000_CDAB, c + 4);
        expect_done(1'b0, 1'b1, 32'h0080_006F, c + 11);
        fork
            mem_txn(1'b0, 3'd2, 32'h0000_1000, 32'd0);
            if_txn(32'h0000_0200);
        join

        // Word store, then readbacks of several lengths
        expect_wr(32'h2000, 8'h44); expect_wr(32'h2001, 8'h33);
        expect_wr(32'h2002, 8'h22); expect_wr(32'h2003, 8'h11);
        c = cyc;
        expect_done(1'b1, 1'b0, 32'd0, c + 5);
        mem_txn(1'b1, 3'd4, 32'h0000_2000, 32'h1122_3344);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h1122_3344, c + 6);
        mem_txn(1'b0, 3'd4, 32'h0000_2000, 32'd0);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h0000_0011, c + 3);
        mem_txn(1'b0, 3'd1, 32'h0000_2003, 32'd0);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h1122_3344, c + 6);
        mem_txn(1'b0, 3'd3, 32'h0000_2000, 32'd0);

        // Address wrap at the top of the address space
        expect_wr(32'hFFFF_FFFF, 8'hEF); expect_wr(32'h0000_0000, 8'hBE);
        c = cyc;
        expect_done(1'b1, 1'b0, 32'd0, c + 3);
        mem_txn(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_BEEF);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h0000_BEEF, c + 4);
        mem_txn(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd0);

        // IF request at an edge with the branch flag high is not granted
        c = cyc;
        expect_done(1'b0, 1'b1, 32'h5634_12B7, c + 7);
        if_addr_in = 32'h0000_0400; if_req_in = 1'b1; branch_flag_in = 1'b1;
        @(negedge clk_in);
        branch_flag_in = 1'b0;
        wait_done(1'b0);
        if_req_in = 1'b0;
        @(negedge clk_in);

        // Branch at E2 of an IF fetch, followed straight away by a MEM load
        c = cyc;
        if_addr_in = 32'h0000_0300; if_req_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        branch_flag_in = 1'b1; if_req_in = 1'b0;
        @(negedge clk_in);
        branch_flag_in = 1'b0;
        chk("flush_ram_wr", 32'(ram_wr_out), 32'd0);
`ifdef MEM_ARB_BRANCH_ABORT_EN
        chk("flush_ram_a", ram_a_out, 32'h0000_0301);
        expect_done(1'b1, 1'b1, 32'h0000_00AB, c + 6);
`else
        chk("flush_ram_a", ram_a_out, 32'h0000_0302);
        expect_done(1'b1, 1'b1, 32'h0000_00AB, c + 10);
`endif
        mem_txn(1'b0, 3'd1, 32'h0000_1000, 32'd0);
        chk("flush_if_data_kept", if_data_out, 32'h5634_12B7);

        // rdy_in low for 3 cycles in the middle of a word store
        expect_wr(32'h3000, 8'hD4); expect_wr(32'h3001, 8'hC3);
        expect_wr(32'h3002, 8'hB2); expect_wr(32'h3003, 8'hA1);
        c = cyc;
        expect_done(1'b1, 1'b0, 32'd0, c + 8);
        mem_wr_in = 1'b1; mem_len_in = 3'd4; mem_addr_in = 32'h0000_3000;
        mem_wdata_in = 32'hA1B2_C3D4; mem_req_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("stall_ram_a", ram_a_out, 32'h0000_3001);
            chk("stall_ram_dout", 32'(ram_dout_out), 32'h0000_00C3);
            chk("stall_ram_wr", 32'(ram_wr_out), 32'd1);
        end
        rdy_in = 1'b1;
        wait_done(1'b1);
        mem_req_in = 1'b0;
        @(negedge clk_in);

        // Reset in the middle of a load, then a fresh load
        mem_wr_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h0000_2000; mem_req_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1; mem_req_in = 1'b0;
        @(negedge clk_in);
        chk_all_zero("midrst");
        rst_in = 1'b0;
        @(negedge clk_in);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h0000_CDAB, c + 4);
        mem_txn(1'b0, 3'd2, 32'h0000_1000, 32'd0);

        repeat (5) @(negedge clk_in);
        chk("pending_done", 32'(exp_q.size()), 32'd0);
        chk("pending_writes", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single byte-wide RAM port between the instruction-fetch stage and the memory-access stage. Accepts one word-or-sub-word transaction at a time, sequences it as consecutive byte accesses, and assembles or scatters little-endian data. Returns a one-cycle done pulse to the winning requester, which holds its pipeline stall request until that pulse. Sits between the IF/MEM stages and the top-level RAM pins.

## Interface
Parameters:
- none

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge
- rst_in  input  1  reset; synchronous and active-high
- rdy_in  input  1  global enable; when 0 every register holds
- branch_flag_in  input  1  pipeline flush from EX; affects IF transactions only
- if_req_in  input  1  fetch request; held until if_done_out
- if_addr_in  input  32  fetch address; always a 4-byte read
- if_data_out  output  32  fetched word; valid while if_done_out=1
- if_done_out  output  1  one-cycle completion pulse to IF
- mem_req_in  input  1  load/store request; held until mem_done_out
- mem_wr_in  input  1  1 = store, 0 = load
- mem_len_in  input  3  byte count: 1, 2 or 4; any other value treated as 4
- mem_addr_in  input  32  start byte address
- mem_wdata_in  input  32  store data; byte i = bits [8i+7:8i]
- mem_rdata_out  output  32  load data, zero-extended; valid while mem_done_out=1
- mem_done_out  output  1  one-cycle completion pulse to MEM
- ram_din_in  input  8  byte returned by RAM
- ram_dout_out  output  8  byte written to RAM
- ram_a_out  output  32  RAM byte address
- ram_wr_out  output  1  RAM write strobe (1 = write)

## Operation
- Reset: state IDLE; all outputs 0; byte counter 0; assembly register 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: mem_req_in has priority over if_req_in (older instruction). MEM store -> WRITE; MEM load or IF -> READ. Latched at grant: owner, address, length n, write data. An IF request at an edge with branch_flag_in=1 is not granted.
- READ: ram_a_out = base+i for i = 0..n-1 on consecutive cycles. Byte for address base+i is captured into bits [8i+7:8i] two edges after ram_a_out first shows it (synchronous RAM latency 1). Unread bytes are 0. After the last byte is captured -> DONE.
- WRITE: ram_a_out = base+i, ram_dout_out = byte i, ram_wr_out=1 for i = 0..n-1; then ram_wr_out=0 -> DONE.
- DONE: exactly one cycle; owner's done pulse high with data; requests are ignored in this cycle -> IDLE. Requester deasserts req on the edge ending DONE.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- Branch during an IF READ: see Configuration. MEM transactions are never aborted by branch_flag_in.
- rdy_in=0: state, counter, address, data, and outputs are frozen (a done pulse is extended until rdy_in returns).

## Timing
- Grant edge E0; the first address is visible after E0.
- Read of n bytes: captures occur at E2..E(n+1); DONE is entered after E(n+1); the done pulse is visible after E(n+1). IF fetch: done 5 cycles after grant.
- Write of n bytes: strobes occur after E0..E(n-1); ram_wr_out=0 after En; the done pulse is visible after En.
- Minimum spacing: the next grant occurs at the edge ending IDLE following DONE, i.e. at least 2 cycles after the done pulse begins.
- Reset mid-transaction: the next cycle is IDLE with ram_wr_out=0; no done pulse; partial data is discarded.

## Configuration
- MEM_ARB_BRANCH_ABORT_EN defined: branch_flag_in=1 at an edge during an IF READ sends the FSM to IDLE immediately. There is no if_done_out. ram_a_out holds its last value and ram_wr_out stays 0. MEM may be granted from the following edge.
- Not defined: the IF READ runs to completion and DONE is entered. if_done_out is suppressed for that transaction (discard flag), so the flushed fetch's data never reaches IF.

## Test plan
- IF fetch at 0x00000100, RAM bytes 13 05 00 00 -> ram_a_out steps 0x100..0x103; if_done_out pulses after E5 with if_data_out=0x00000513.
- Simultaneous if_req_in and mem_req_in (load, len 2, addr 0x1000, bytes AB CD) -> MEM wins; mem_rdata_out=0x0000CDAB after E3; IF is granted afterwards.
- Store len 4, addr 0x2000, data 0x11223344 -> writes 44,33,22,11 to 0x2000..0x2003 on 4 strobed cycles; mem_done_out pulses after E4.
- branch_flag_in at E2 of an IF fetch -> with MEM_ARB_BRANCH_ABORT_EN: IDLE at E2, no done; without: completes with no if_done_out.
- rdy_in low for 3 cycles mid-store -> ram_a_out and ram_dout_out are held; the byte sequence and done timing resume shifted by 3 cycles.
- rst_in asserted mid-load -> all outputs 0 next cycle; a fresh request afterwards completes normally.
